// File: rtl/adder_pkg.sv
// Shared definitions for the 32-bit accumulating adder: datapath width and FSM state encoding.
package adder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/BypassAdder_32bits.sv
// 32-bit carry-bypass (carry-skip) adder built from 4-bit ripple blocks.
// A block whose bits all propagate passes its incoming carry straight through.
module BypassAdder_32bits
  import adder_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  localparam int BLK_W = 4;
  localparam int N_BLK = DATA_W / BLK_W;

  // Ripple inside each block; skip mux selects the block carry-out.
  always_comb begin
    logic c_blk;
    logic c_rip;
    logic prop_all;
    sum      = '0;
    c_blk    = cin;
    c_rip    = 1'b0;
    prop_all = 1'b0;
    for (int k = 0; k < N_BLK; k++) begin
      c_rip    = c_blk;
      prop_all = 1'b1;
      for (int j = 0; j < BLK_W; j++) begin
        sum[k*BLK_W+j] = a[k*BLK_W+j] ^ b[k*BLK_W+j] ^ c_rip;
        c_rip          = (a[k*BLK_W+j] & b[k*BLK_W+j]) |
                         ((a[k*BLK_W+j] ^ b[k*BLK_W+j]) & c_rip);
        prop_all       = prop_all & (a[k*BLK_W+j] ^ b[k*BLK_W+j]);
      end
      if (prop_all) begin
        c_blk = c_blk;
      end else begin
        c_blk = c_rip;
      end
    end
    cout = c_blk;
  end

endmodule

// File: rtl/adder_accum_32bits.sv
// Accumulates a stream of 32-bit beats into a sum presented with a valid/ready handshake.
// Optional macro ACC_OVF_SAT_EN: saturate the sum to all-ones on the first carry-out.
module adder_accum_32bits
  import adder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic [CNT_W-1:0]  out_count
);

  state_e             state;
  state_e             state_next;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  acc_next;
  logic [DATA_W-1:0]  add_sum;
  logic               add_cout;
  logic               carry;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic               valid_r;
  logic               accept;

  assign in_ready  = !rst && (state != HOLD) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_r;
  assign out_sum   = acc;
  assign out_cout  = carry;
  assign out_count = count;

  BypassAdder_32bits u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Saturating increment as a half-adder chain, keeping the data adder the only adder.
  always_comb begin
    logic c;
    c         = 1'b1;
    count_inc = count;
    if (&count) begin
      count_inc = count;
    end else begin
      for (int i = 0; i < CNT_W; i++) begin
        count_inc[i] = count[i] ^ c;
        c            = c & count[i];
      end
    end
  end

  always_comb begin
`ifdef ACC_OVF_SAT_EN
    if (carry || add_cout) begin
      acc_next = '1;
    end else begin
      acc_next = add_sum;
    end
`else
    acc_next = add_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (clear) begin
          state_next = IDLE;
        end else if (accept) begin
          state_next = in_last ? HOLD : ACCUM;
        end else begin
          state_next = state;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; HOLD ignores clear and only drains on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      carry   <= 1'b0;
      count   <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= (state_next == HOLD);
      if (state == HOLD) begin
        if (out_ready) begin
          acc   <= '0;
          carry <= 1'b0;
          count <= '0;
        end
      end else if (clear) begin
        acc   <= '0;
        carry <= 1'b0;
        count <= '0;
      end else if (accept) begin
        acc   <= acc_next;
        carry <= carry | add_cout;
        count <= count_inc;
      end
    end
  end

endmodule
